// File: rtl/bmp_pkg.sv
// -----------------------------------------------------------------------------
// bmp_pkg
// Shared definitions for the BMP pixel gate: parser FSM encoding, header field
// byte offsets, signature bytes, the only accepted pixel depth and the minimum
// legal pixel-data offset. Also a helper for the per-row padding amount.
// -----------------------------------------------------------------------------
package bmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_GAP    = 3'd2,
    ST_PIXEL  = 3'd3,
    ST_PAD    = 3'd4,
    ST_TRAIL  = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Little-endian header fields, first byte of each.
  localparam int OFF_OFFSET = 10;
  localparam int OFF_WIDTH  = 18;
  localparam int OFF_HEIGHT = 22;
  localparam int OFF_BPP    = 28;
  // Last header byte that takes part in the checks (upper bpp byte).
  localparam int HDR_LAST   = OFF_BPP + 1;

  localparam logic [7:0]  SIG0   = 8'h42;  // 'B'
  localparam logic [7:0]  SIG1   = 8'h4D;  // 'M'
  localparam logic [15:0] BPP_24 = 16'd24;
  localparam int          HDR_MIN = 54;

  // Rows are padded to a multiple of 4 bytes: pad = (-row_bytes) mod 4.
  function automatic logic [1:0] row_pad(input logic [1:0] row_bytes_lsb);
    return 2'd0 - row_bytes_lsb;
  endfunction

endpackage

// File: rtl/bmp_pixel_gate_if.sv
// -----------------------------------------------------------------------------
// bmp_pixel_gate_if
// Byte-stream bundle around the pixel gate.
//   Input side : frame_start, byte_in[7:0], byte_valid
//   Output side: point_data_out[7:0], point_valid, image_process_start
// master = stream source / sink (testbench or upstream), slave = the gate.
// -----------------------------------------------------------------------------
interface bmp_pixel_gate_if;
  logic       frame_start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] point_data_out;
  logic       point_valid;
  logic       image_process_start;

  modport master (
    output frame_start, byte_in, byte_valid,
    input  point_data_out, point_valid, image_process_start
  );

  modport slave (
    input  frame_start, byte_in, byte_valid,
    output point_data_out, point_valid, image_process_start
  );
endinterface

// File: rtl/bmp_row_tracker.sv
// -----------------------------------------------------------------------------
// bmp_row_tracker
// Walks the pixel area of a BMP one accepted byte at a time: pixel bytes of a
// row, then its padding, then the next row.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        restart at row 0, column 0, pixel phase
//   advance      one pixel-area byte accepted this cycle
//   row_bytes    3*width (DIM_W+2 bits)
//   pad          padding bytes per row (0..3)
//   height       number of rows
//   in_pixel     phase of the byte that follows the current one is pixel
//   in_pad       phase of the byte that follows the current one is padding
//   row_end      the advancing byte is the last byte of its row
//   frame_end    the advancing byte is the last byte of the last row
// -----------------------------------------------------------------------------
module bmp_row_tracker #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W+1:0] row_bytes,
  input  logic [1:0]       pad,
  input  logic [DIM_W-1:0] height,
  output logic             in_pixel,
  output logic             in_pad,
  output logic             row_end,
  output logic             frame_end
);

  localparam int RB_W  = DIM_W + 2;
  localparam int CNT_W = DIM_W + 1;

  logic [RB_W-1:0]  col_reg;
  logic [1:0]       pad_cnt_reg;
  logic [DIM_W-1:0] row_reg;
  logic             pad_phase_reg;
  logic             pad_phase_next;
  logic             last_pix;
  logic             last_pad;

  assign last_pix = !pad_phase_reg && (col_reg == row_bytes - RB_W'(1));
  assign last_pad =  pad_phase_reg && (pad_cnt_reg == pad - 2'd1);

  assign row_end   = advance && ((last_pix && (pad == 2'd0)) || last_pad);
  assign frame_end = row_end &&
                     (({1'b0, row_reg} + CNT_W'(1)) == {1'b0, height});

  always_comb begin
    pad_phase_next = pad_phase_reg;
    if (advance) begin
      if (last_pix && (pad != 2'd0)) pad_phase_next = 1'b1;
      else if (last_pad)             pad_phase_next = 1'b0;
    end
  end

  assign in_pad   = pad_phase_next;
  assign in_pixel = !pad_phase_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      pad_cnt_reg   <= '0;
      row_reg       <= '0;
      pad_phase_reg <= 1'b0;
    end else if (clear) begin
      col_reg       <= '0;
      pad_cnt_reg   <= '0;
      row_reg       <= '0;
      pad_phase_reg <= 1'b0;
    end else if (advance) begin
      if (!pad_phase_reg) col_reg     <= last_pix ? '0 : col_reg + RB_W'(1);
      else                pad_cnt_reg <= last_pad ? '0 : pad_cnt_reg + 2'd1;
      pad_phase_reg <= pad_phase_next;
      if (row_end) row_reg <= row_reg + DIM_W'(1);
    end
  end

endmodule

// File: rtl/bmp_pixel_gate.sv
// -----------------------------------------------------------------------------
// bmp_pixel_gate
// Parses a 24-bit BMP byte stream and forwards every byte unchanged one cycle
// later, flagging true pixel bytes with image_process_start so the downstream
// point-process stage leaves header, gap, padding and trailer bytes alone.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   s (slave)              byte stream in / forwarded stream out
//   img_width, img_height  dimensions of the last accepted header
//   hdr_error              header rejected; sticky until next frame_start
//   frame_done             pulse with the last byte of the last row
// -----------------------------------------------------------------------------
module bmp_pixel_gate #(
  parameter int DIM_W   = 16,
  parameter int HDR_MIN = bmp_pkg::HDR_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  bmp_pixel_gate_if.slave  s,
  output logic [DIM_W-1:0] img_width,
  output logic [DIM_W-1:0] img_height,
  output logic             hdr_error,
  output logic             frame_done
);
  import bmp_pkg::*;

  localparam int RB_W = DIM_W + 2;

  state_t           state_reg, state_next;
  logic [31:0]      byte_cnt_reg;
  logic             sig0_ok_reg;
  logic [31:0]      offset_reg, width_reg, height_reg;
  logic [7:0]       bpp_lo_reg;
  logic [DIM_W-1:0] img_width_reg, img_height_reg;
  logic [7:0]       data_out_reg;
  logic             valid_out_reg, start_out_reg, hdr_error_reg, frame_done_reg;

  logic             restart, step;
  logic [15:0]      bpp;
  logic             hdr_ok;
  logic [RB_W-1:0]  row_bytes;
  logic [1:0]       pad;
  logic             start_next, err_set, hdr_accept, advance;
  logic             trk_in_pixel, trk_in_pad, trk_row_end, trk_frame_end;
  logic [3:0]       lane_off, lane_wid, lane_hgt;

  // frame_start only means something on a valid byte; that byte is byte 0.
  assign restart = s.byte_valid &  s.frame_start;
  assign step    = s.byte_valid & ~s.frame_start;

  // Byte-lane decode for the three 32-bit little-endian header fields.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_off[gi] = (byte_cnt_reg == 32'(OFF_OFFSET + gi));
    assign lane_wid[gi] = (byte_cnt_reg == 32'(OFF_WIDTH  + gi));
    assign lane_hgt[gi] = (byte_cnt_reg == 32'(OFF_HEIGHT + gi));
  end

  // Evaluated while byte 29 is on the input, so its upper bpp byte is live.
  // A negative height is caught by the non-zero upper bytes test.
  assign bpp    = {s.byte_in, bpp_lo_reg};
  assign hdr_ok = (bpp == BPP_24) &&
                  (offset_reg >= 32'(HDR_MIN)) &&
                  (width_reg[DIM_W-1:0]  != '0) &&
                  (height_reg[DIM_W-1:0] != '0) &&
                  ((width_reg  >> DIM_W) == 32'd0) &&
                  ((height_reg >> DIM_W) == 32'd0);

  assign row_bytes = {2'b00, img_width_reg} + {1'b0, img_width_reg, 1'b0};
  assign pad       = row_pad(row_bytes[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start_next = 1'b0;
    err_set    = 1'b0;
    hdr_accept = 1'b0;
    advance    = 1'b0;
    if (restart) begin
      state_next = ST_HEADER;
    end else if (step) begin
      case (state_reg)
        ST_HEADER: begin
          if ((byte_cnt_reg == 32'd1) && (!sig0_ok_reg || (s.byte_in != SIG1))) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
          end else if (byte_cnt_reg == 32'(HDR_LAST)) begin
            if (hdr_ok) begin
              state_next = ST_GAP;
              hdr_accept = 1'b1;
            end else begin
              state_next = ST_ERR;
              err_set    = 1'b1;
            end
          end
        end
        // offset >= HDR_MIN > 30, so offset-1 is always reached from GAP.
        ST_GAP: begin
          if (byte_cnt_reg == offset_reg - 32'd1) state_next = ST_PIXEL;
        end
        ST_PIXEL, ST_PAD: begin
          advance    = 1'b1;
          start_next = (state_reg == ST_PIXEL);
          if (trk_frame_end)     state_next = ST_TRAIL;
          else if (trk_in_pad)   state_next = ST_PAD;
          else if (trk_in_pixel) state_next = ST_PIXEL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg   <= '0;
      sig0_ok_reg    <= 1'b0;
      offset_reg     <= '0;
      width_reg      <= '0;
      height_reg     <= '0;
      bpp_lo_reg     <= '0;
      img_width_reg  <= '0;
      img_height_reg <= '0;
      data_out_reg   <= '0;
      valid_out_reg  <= 1'b0;
      start_out_reg  <= 1'b0;
      hdr_error_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      valid_out_reg  <= s.byte_valid;
      start_out_reg  <= start_next;
      frame_done_reg <= advance & trk_frame_end;
      if (s.byte_valid) data_out_reg <= s.byte_in;

      if (restart) begin
        byte_cnt_reg  <= 32'd1;
        sig0_ok_reg   <= (s.byte_in == SIG0);
        hdr_error_reg <= 1'b0;
        offset_reg    <= '0;
        width_reg     <= '0;
        height_reg    <= '0;
        bpp_lo_reg    <= '0;
      end else if (step) begin
        // Position is only needed up to the pixel offset; saturate, never wrap.
        if (((state_reg == ST_HEADER) || (state_reg == ST_GAP)) && (byte_cnt_reg != '1))
          byte_cnt_reg <= byte_cnt_reg + 32'd1;
        if (state_reg == ST_HEADER) begin
          for (int i = 0; i < 4; i++) begin
            if (lane_off[i]) offset_reg[8*i +: 8] <= s.byte_in;
            if (lane_wid[i]) width_reg[8*i +: 8]  <= s.byte_in;
            if (lane_hgt[i]) height_reg[8*i +: 8] <= s.byte_in;
          end
          if (byte_cnt_reg == 32'(OFF_BPP)) bpp_lo_reg <= s.byte_in;
        end
        if (err_set) hdr_error_reg <= 1'b1;
        if (hdr_accept) begin
          img_width_reg  <= width_reg[DIM_W-1:0];
          img_height_reg <= height_reg[DIM_W-1:0];
        end
      end
    end
  end

  bmp_row_tracker #(.DIM_W(DIM_W)) u_row_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .advance   (advance),
    .row_bytes (row_bytes),
    .pad       (pad),
    .height    (img_height_reg),
    .in_pixel  (trk_in_pixel),
    .in_pad    (trk_in_pad),
    .row_end   (trk_row_end),
    .frame_end (trk_frame_end)
  );

  assign s.point_data_out      = data_out_reg;
  assign s.point_valid         = valid_out_reg;
  assign s.image_process_start = start_out_reg;
  assign img_width             = img_width_reg;
  assign img_height            = img_height_reg;
  assign hdr_error             = hdr_error_reg;
  assign frame_done            = frame_done_reg;

  // Row end without frame end only matters inside the tracker.
  logic unused_row_end;
  assign unused_row_end = trk_row_end;

endmodule

// File: doc/bmp_pixel_gate.md
# bmp_pixel_gate

Upstream stage of the point-process chain (contrast/brightness adjust). Accepts a raw 24-bit BMP file as a byte stream, parses the header, and forwards every byte unchanged with a 1-cycle latency. It also generates `image_process_start`, cycle-aligned with each forwarded byte and high only for true pixel bytes. Header, header-to-pixel gap, row padding and trailing bytes reach the point-process stage unmodified, so the output file remains a valid BMP.

## Interface
- `DIM_W`, 16: width of the width/height fields and row counters. The upper header bytes of width/height above `DIM_W` must be zero.
- `HDR_MIN`, 54: minimum legal pixel-data offset.
- `clk` input 1: system clock.
- `rst_n` input 1: reset; one clock, reset asynchronous and active-low.
- `frame_start` input 1: qualifies the current `byte_valid` byte as file byte 0.
- `byte_in` input 8: file byte.
- `byte_valid` input 1: `byte_in` valid this cycle; the stream may have gaps.
- `point_data_out` output 8: registered copy of the last accepted `byte_in`.
- `point_valid` output 1: registered `byte_valid`.
- `image_process_start` output 1: current `point_data_out` is a pixel byte. Feeds the point-process start input directly.
- `img_width`, `img_height` output DIM_W: parsed dimensions; valid once the header is accepted.
- `hdr_error` output 1: sticky until the next `frame_start`; header rejected.
- `frame_done` output 1: one-cycle pulse with the last byte of the last row, padding included.

## Operation
- States:
  - IDLE: a byte with `frame_start` goes to HEADER, byte_cnt=1.
  - HEADER: counts and captures fields.
  - GAP: bytes between the header and the pixel offset.
  - PIXEL
  - PAD
  - TRAIL: after the last row; pass-through only.
  - ERR
- Header field capture, little-endian, by byte_cnt:
  - 0..1: must be 0x42, 0x4D.
  - 10..13: `offset`.
  - 18..21: width.
  - 22..25: height.
  - 28..29: bpp.
- Checks, evaluated when byte 29 is accepted; any failure enters ERR:
  - signature wrong;
  - bpp ≠ 24;
  - offset < HDR_MIN;
  - width = 0 or height = 0;
  - height negative or upper bytes non-zero.
- A signature failure enters ERR on byte 1.
- Leaving HEADER/GAP:
  - The byte with index `offset-1` moves the FSM to PIXEL.
  - This includes byte 53 for offset 54.
  - Bytes 30..offset-1 are forwarded with start=0.
- Row geometry:
  - row_bytes = 3·width, held in DIM_W+2 bits.
  - pad = (4 − row_bytes mod 4) mod 4.
- In PIXEL, each accepted byte:
  - gets start=1;
  - increments col;
  - at col = row_bytes−1, goes to PAD if pad≠0, otherwise ends the row.
- In PAD, bytes get start=0; after `pad` bytes the row ends.
- Row end:
  - row increments;
  - if row = height, `frame_done` and TRAIL;
  - else PIXEL.
- TRAIL and ERR forward bytes with start=0 until the next `frame_start`.
- `frame_start` in any state restarts parsing at byte 0 (that byte counts as byte 0) and clears `hdr_error`.
- A truncated file (new `frame_start` before completion) causes no error flag; the new frame simply restarts.
- Bytes without `byte_valid` are ignored; no counter advances.

## Timing
- Latency: exactly 1 cycle from `byte_in`/`byte_valid` to `point_data_out`/`point_valid`/`image_process_start`.
- All three update on the same edge, because the next stage registers data and start together.
- When `byte_valid`=0:
  - `point_valid` goes 0;
  - `point_data_out` holds its value;
  - `image_process_start` goes 0.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Asynchronous reset mid-frame aborts immediately. The next frame needs `frame_start`.
- `hdr_error` rises in the cycle the failing byte appears on `point_data_out`.
- `frame_done` coincides with `point_valid` for the final row byte: the last pad byte, or the last pixel byte if pad=0.
- byte_cnt saturates at all-ones; no wrap.

## Structure
- Shared package `bmp_pkg` holds:
  - the FSM state encoding;
  - the header field offsets (10, 18, 22, 28);
  - the signature bytes;
  - BPP_24 = 24;
  - HDR_MIN.
- One sub-module, `bmp_row_tracker`:
  - inputs: row_bytes, pad, height, advance strobe;
  - outputs: in_pixel, in_pad, row_end, frame_end.
- The top level holds the header capture, checks and output registers.

## Test plan
- 2×2 image, offset 54, 70 bytes, bytes 54..69:
  - start high for bytes 54–59 and 62–67;
  - start low for 60–61 and 68–69;
  - `frame_done` with byte 69;
  - `img_width`=2, `img_height`=2.
- 4×1 image, offset 58, 4 trailing bytes:
  - start low through byte 57;
  - start high for bytes 58–69;
  - pad=0, so `frame_done` with byte 69;
  - bytes 70–73 start low.
- Byte 1 = 0x4E:
  - `hdr_error` with that byte;
  - start never high;
  - all bytes forwarded unchanged.
- bpp=8: `hdr_error` rises with byte 29.
- 2×2 stream with `byte_valid` gaps of 1–3 cycles:
  - identical start pattern over the valid bytes;
  - `point_valid` low in the gaps.
- `frame_start` at file byte 60, followed by a full 2×2 frame:
  - the second frame is parsed correctly.
- Reset asserted at byte 40, then a new frame:
  - outputs 0 during reset;
  - correct parsing afterwards.
